// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the micro-PC, decodes the control word into
// datapath enables and stalls on memory microinstructions. Optional trap on
// illegal opcodes is enabled by defining MSEQ_ILLEGAL_TRAP_EN.
module micro_sequencer #(
    parameter int UADDR_W     = 4,
    parameter int CW_W        = 17,
    parameter int FETCH_UADDR = 0,
    parameter int ALUWB_UADDR = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CW_W-1:0]    cw,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [UADDR_W-1:0] uaddr,
    output logic               pc_write,
    output logic               reg_write,
    output logic               mem_write,
    output logic               ir_write,
    output logic               adr_src,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               mem_req,
    output logic               instr_done
`ifdef MSEQ_ILLEGAL_TRAP_EN
    ,
    output logic               illegal
`endif
);

    localparam logic [UADDR_W-1:0] LP_FETCH = UADDR_W'(FETCH_UADDR);
    localparam logic [UADDR_W-1:0] LP_ALUWB = UADDR_W'(ALUWB_UADDR);

    logic [UADDR_W-1:0] r_uaddr;
    logic [2:0]         w_seq;
    logic [UADDR_W-1:0] w_d1_tgt;
    logic               w_d1_hit;
    logic [UADDR_W-1:0] w_disp1;
    logic [UADDR_W-1:0] w_disp2;
    logic [UADDR_W-1:0] w_next;
    logic               w_req_raw;
    logic               w_stall;
    logic               w_freeze;
    logic               w_en_ok;

    assign w_seq = cw[2:0];

    always_comb begin
        w_d1_tgt = LP_FETCH;
        w_d1_hit = 1'b0;
        case (opcode)
            7'b0000011, 7'b0100011: begin w_d1_tgt = UADDR_W'(2);  w_d1_hit = 1'b1; end
            7'b0110011:             begin w_d1_tgt = UADDR_W'(6);  w_d1_hit = 1'b1; end
            7'b0010011:             begin w_d1_tgt = UADDR_W'(8);  w_d1_hit = 1'b1; end
            7'b1101111:             begin w_d1_tgt = UADDR_W'(9);  w_d1_hit = 1'b1; end
            7'b1100011:             begin w_d1_tgt = UADDR_W'(10); w_d1_hit = 1'b1; end
            default:                begin w_d1_tgt = LP_FETCH;     w_d1_hit = 1'b0; end
        endcase
    end

    assign w_disp1 = w_d1_hit ? w_d1_tgt : LP_FETCH;

    always_comb begin
        w_disp2 = LP_FETCH;
        case (opcode)
            7'b0000011: w_disp2 = UADDR_W'(3);
            7'b0100011: w_disp2 = UADDR_W'(5);
            default:    w_disp2 = LP_FETCH;
        endcase
    end

    always_comb begin
        w_next = LP_FETCH;
        case (w_seq)
            3'b000:  w_next = r_uaddr + UADDR_W'(1);
            3'b001:  w_next = w_disp1;
            3'b010:  w_next = w_disp2;
            3'b100:  w_next = LP_ALUWB;
            default: w_next = LP_FETCH;
        endcase
    end

    // Fetch (ir_write) and data accesses (adr_src) are the memory microinstructions.
    assign w_req_raw = cw[12] | cw[11];
    assign w_stall   = w_req_raw & ~mem_ready;

`ifdef MSEQ_ILLEGAL_TRAP_EN
    logic r_halted;
    logic w_trap;

    assign w_trap   = (w_seq == 3'b001) & ~w_d1_hit & ~r_halted;
    assign w_freeze = reset | r_halted | w_trap;
    assign illegal  = r_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (w_trap) begin
            r_halted <= 1'b1;
        end
    end
`else
    assign w_freeze = reset;
`endif

    assign w_en_ok = ~w_freeze & ~w_stall;

    // Write enables drop during a stall; strobes and selects keep the access stable.
    assign pc_write   = w_en_ok & (cw[15] | (cw[16] & zero));
    assign reg_write  = w_en_ok & cw[14];
    assign ir_write   = w_en_ok & cw[12];
    assign mem_write  = ~w_freeze & cw[13];
    assign mem_req    = ~w_freeze & w_req_raw;
    assign instr_done = w_en_ok & (w_next == LP_FETCH);

    assign adr_src    = cw[11];
    assign result_src = cw[10:9];
    assign alu_src_a  = cw[8:7];
    assign alu_src_b  = cw[6:5];
    assign alu_op     = cw[4:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_uaddr <= LP_FETCH;
        end else if (w_en_ok) begin
            r_uaddr <= w_next;
        end
    end

    assign uaddr = r_uaddr;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: microprogram ROM, directed instruction runs and
// randomized control words checked against a rule-level reference model.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] cw;
    logic [16:0] cw_rand;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  uaddr;
    logic        pc_write, reg_write, mem_write, ir_write, adr_src;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
    logic        mem_req, instr_done;
`ifdef MSEQ_ILLEGAL_TRAP_EN
    logic        illegal;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        use_rom;
    logic [16:0] rom [16];

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_uaddr;
    bit         m_halted;
    bit         m_done;
    logic [3:0] s_uaddr;
    logic       s_pcw;

    logic [6:0] d1_ops [6] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63};
    int         d1_tgt [6] = '{2, 2, 6, 8, 9, 10};

    always #5 clk = ~clk;

    assign cw = use_rom ? rom[uaddr] : cw_rand;

    micro_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cw         (cw),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .uaddr      (uaddr),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .adr_src    (adr_src),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .mem_req    (mem_req),
        .instr_done (instr_done)
`ifdef MSEQ_ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mk_cw(input bit br, input bit pcu, input bit rw, input bit mw,
                                          input bit irw, input bit adr, input logic [1:0] res,
                                          input logic [1:0] sa, input logic [1:0] sb,
                                          input logic [1:0] op, input logic [2:0] seq);
        return {br, pcu, rw, mw, irw, adr, res, sa, sb, op, seq};
    endfunction

    // One clock of the reference model: check outputs, then advance model state.
    task automatic step(input logic r, input logic [6:0] op, input logic z, input logic mr);
        logic [16:0] c;
        logic [3:0]  tgt;
        bit          legal, trap, frozen, stall, req;
        reset = r; opcode = op; zero = z; mem_ready = mr;
        #1;
        c     = use_rom ? rom[m_uaddr] : cw_rand;
        req   = c[12] | c[11];
        legal = 1'b0;
        tgt   = 4'd0;
        case (c[2:0])
            3'd0: tgt = m_uaddr + 4'd1;
            3'd1: for (int k = 0; k < 6; k++)
                      if (op == d1_ops[k]) begin tgt = 4'(d1_tgt[k]); legal = 1'b1; end
            3'd2: tgt = (op == 7'h03) ? 4'd3 : (op == 7'h23) ? 4'd5 : 4'd0;
            3'd4: tgt = 4'd7;
            default: tgt = 4'd0;
        endcase
        trap   = TRAP && !m_halted && (c[2:0] == 3'd1) && !legal;
        frozen = r || m_halted || trap;
        stall  = req && !mr;
        check("uaddr", 32'(uaddr), 32'(m_uaddr));
        check("enables", {pc_write, reg_write, mem_write, ir_write, mem_req, instr_done},
              {!frozen && !stall && (c[15] || (c[16] && z)), !frozen && !stall && c[14],
               !frozen && c[13], !frozen && !stall && c[12], !frozen && req,
               !frozen && !stall && (tgt == 4'd0)});
        check("selects", {adr_src, result_src, alu_src_a, alu_src_b, alu_op},
              {c[11], c[10:9], c[8:7], c[6:5], c[4:3]});
`ifdef MSEQ_ILLEGAL_TRAP_EN
        check("illegal", 32'(illegal), 32'(m_halted));
`endif
        s_uaddr = m_uaddr;
        s_pcw   = pc_write;
        m_done  = !frozen && !stall && (tgt == 4'd0);
        if (r) begin
            m_uaddr  = 4'd0;
            m_halted = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (trap) begin
            m_halted = 1'b1;
        end else if (!stall) begin
            m_uaddr = tgt;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run one instruction from Fetch; smask selects addresses that stall stall_n cycles.
    task automatic run_instr(input string name, input logic [6:0] op, input logic z,
                             input int stall_n, input logic [15:0] smask,
                             input logic [31:0] exp_seq, input int exp_len,
                             input int probe_a, input logic probe_pcw);
        int          left [16];
        logic [3:0]  tr [$];
        logic [16:0] c;
        logic        mr;
        bit          done;
        logic        seen, cap;
        done = 1'b0; seen = 1'b0; cap = 1'b0;
        for (int i = 0; i < 16; i++) left[i] = smask[i] ? stall_n : 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (tr.size() == 0 || tr[$] !== uaddr) tr.push_back(uaddr);
            c  = rom[m_uaddr];
            mr = 1'b1;
            if ((c[12] | c[11]) && left[m_uaddr] > 0) begin
                mr = 1'b0;
                left[m_uaddr]--;
            end
            step(1'b0, op, z, mr);
            if (probe_a >= 0 && 32'(s_uaddr) == probe_a) begin seen = 1'b1; cap = s_pcw; end
            done = m_done;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        if (tr[$] !== uaddr) tr.push_back(uaddr);
        check({name, "_len"}, 32'(tr.size()), 32'(exp_len));
        for (int i = 0; i < exp_len; i++)
            check({name, "_seq"}, (i < tr.size()) ? 32'(tr[i]) : 32'hFFFF, 32'(exp_seq[4*i +: 4]));
        if (probe_a >= 0) check({name, "_pcw"}, {seen, cap}, {1'b1, probe_pcw});
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 17'd0;
        rom[0]  = mk_cw(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
        rom[1]  = mk_cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b001);
        rom[2]  = mk_cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010);
        rom[3]  = mk_cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        rom[4]  = mk_cw(0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011);
        rom[5]  = mk_cw(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b011);
        rom[6]  = mk_cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b100);
        rom[7]  = mk_cw(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b011);
        rom[8]  = mk_cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b100);
        rom[9]  = mk_cw(0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b100);
        rom[10] = mk_cw(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b011);

        use_rom = 1'b1; cw_rand = 17'd0;
        reset = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        m_uaddr = 4'd0; m_halted = 1'b0;
        step(1'b1, 7'h33, 1'b1, 1'b1);

        run_instr("rtype", 7'h33, 1'b0, 0, 16'h0000, 32'h07610, 5, 7, 1'b0);
        run_instr("lw",    7'h03, 1'b0, 3, 16'h0009, 32'h043210, 6, -1, 1'b0);
        run_instr("sw",    7'h23, 1'b0, 2, 16'h0021, 32'h05210, 5, -1, 1'b0);
        run_instr("beq1",  7'h63, 1'b1, 0, 16'h0000, 32'h0A10, 4, 10, 1'b1);
        run_instr("beq0",  7'h63, 1'b0, 0, 16'h0000, 32'h0A10, 4, 10, 1'b0);
        run_instr("jal",   7'h6F, 1'b0, 0, 16'h0000, 32'h07910, 5, 9, 1'b1);
        run_instr("itype", 7'h13, 1'b0, 1, 16'h0001, 32'h07810, 5, -1, 1'b0);

`ifdef MSEQ_ILLEGAL_TRAP_EN
        for (int i = 0; i < 6; i++) step(1'b0, 7'h7F, 1'b0, 1'b1);
        check("ill_hold_uaddr", 32'(uaddr), 32'd1);
        check("ill_flag", 32'(illegal), 32'd1);
        step(1'b1, 7'h7F, 1'b0, 1'b1);
        check("ill_clr_uaddr", 32'(uaddr), 32'd0);
        check("ill_clr_flag", 32'(illegal), 32'd0);
`else
        run_instr("illegal", 7'h7F, 1'b0, 0, 16'h0000, 32'h010, 3, -1, 1'b0);
`endif

        step(1'b0, 7'h33, 1'b0, 1'b1);
        step(1'b0, 7'h33, 1'b0, 1'b1);
        check("rst6_at", 32'(uaddr), 32'd6);
        step(1'b1, 7'h33, 1'b0, 1'b1);
        check("rst6_uaddr", 32'(uaddr), 32'd0);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 40) == 0), d1_ops[$urandom_range(0, 5)],
                 1'($urandom), ($urandom_range(0, 2) != 0));
        end

        use_rom = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cw_rand = 17'($urandom);
            step(($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 4) == 0) ? 7'($urandom) : d1_ops[$urandom_range(0, 5)],
                 1'($urandom), 1'($urandom));
        end
        use_rom = 1'b1;
        step(1'b1, 7'h33, 1'b0, 1'b1);
        check("final_uaddr", 32'(uaddr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer for the multicycle RV32I control unit.
- Owns the 4-bit micro-PC that addresses the 17-bit control-word ROM, and splits the returned word into datapath control signals.
- Computes the next micro-address from the word's 3-bit sequencing field, the instruction opcode and ALU zero.
- Stalls the microprogram on memory-access microinstructions until the memory handshake completes.

Parameters:
- UADDR_W, 4, micro-address width.
- CW_W, 17, control-word width.
- FETCH_UADDR, 0, micro-address of Fetch.
- ALUWB_UADDR, 7, micro-address of ALUWB.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cw  in  CW_W  control word from the ROM for the current uaddr (combinational ROM).
- opcode  in  7  instr[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- uaddr  out  UADDR_W  ROM address (micro-PC).
- pc_write  out  1  PC write enable.
- reg_write  out  1  register-file write enable.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction-register write enable.
- adr_src  out  1  memory address select.
- result_src  out  2  result mux select.
- alu_src_a  out  2  ALU A-operand select.
- alu_src_b  out  2  ALU B-operand select.
- alu_op  out  2  ALU decoder op.
- mem_req  out  1  memory access requested this cycle.
- instr_done  out  1  one-cycle pulse when the micro-PC returns to Fetch.

Behaviour:
- Control-word layout:
  - [16] branch, [15] pc_update, [14] reg_write, [13] mem_write, [12] ir_write, [11] adr_src.
  - [10:9] result_src, [8:7] alu_src_a, [6:5] alu_src_b, [4:3] alu_op.
  - [2:0] seq.
- seq encoding (next uaddr):
  - 000 = uaddr+1.
  - 001 = dispatch1(opcode).
  - 010 = dispatch2(opcode).
  - 011 = FETCH_UADDR.
  - 100 = ALUWB_UADDR.
  - 101..111 = FETCH_UADDR.
- dispatch1:
  - 0000011 (lw) or 0100011 (sw) -> 2.
  - 0110011 -> 6.
  - 0010011 -> 8.
  - 1101111 -> 9.
  - 1100011 -> 10.
  - any other opcode is illegal -> FETCH_UADDR (see optional feature).
- dispatch2: 0000011 -> 3; 0100011 -> 5; otherwise FETCH_UADDR.
- Control outputs are combinational from cw; the only sequential state is the uaddr register (plus the halt flag when enabled). Latency: uaddr update takes 1 cycle per microinstruction.
- pc_write = pc_update | (branch & zero).
- mem_req = cw[12] | cw[11] (Fetch, MemRead, MemWrite).
- Stall: mem_req=1 and mem_ready=0 ->
  - uaddr holds;
  - pc_write, reg_write and ir_write forced to 0;
  - mem_write, adr_src and the mux selects pass through unchanged.
- mem_req=1 and mem_ready=1 -> enables pass through and uaddr advances.
- mem_req=0 -> mem_ready is ignored.
- instr_done = 1 when the computed next uaddr = FETCH_UADDR and no stall is in effect (this cycle ends the instruction).
- Reset (synchronous, active-high): uaddr <= FETCH_UADDR. While reset=1, all enables (pc_write, reg_write, mem_write, ir_write), mem_req and instr_done are forced to 0. Reset mid-instruction abandons it; no enable is asserted in the reset cycle.
- uaddr+1 wraps modulo 2^UADDR_W. Addresses 11..15 are not populated in the ROM; the ROM returns 0 there, so seq=000 and the micro-PC walks to 15 and wraps to 0. This path is unreachable from legal dispatch.

Optional Feature:
- Macro: MSEQ_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal (1 bit) and an internal halted flag.
  - seq=001 with an opcode outside the dispatch1 list sets halted and illegal (both sticky).
  - While halted: uaddr holds, and all enables, mem_req and instr_done are 0.
  - Only reset clears halted and illegal.
- Undefined:
  - No illegal port.
  - An illegal opcode goes to FETCH_UADDR, with instr_done=1 in that cycle (treated as a NOP).

Test Plan:
- Reset, then R-type (opcode 0110011) with mem_ready tied 1:
  - uaddr sequence 0,1,6,7,0;
  - reg_write=1 only at uaddr 7;
  - instr_done=1 at uaddr 7.
- lw (0000011) with mem_ready held 0 for 3 cycles at uaddr 0 and at uaddr 3:
  - uaddr holds during each stall;
  - ir_write and pc_write are 0 until mem_ready=1;
  - sequence is 0,1,2,3,4,0.
- sw (0100011):
  - sequence 0,1,2,5,0;
  - mem_write=1 throughout the stall at uaddr 5;
  - reg_write never 1.
- beq (1100011), first with zero=1 then with zero=0 at uaddr 10:
  - pc_write = 1 and 0 respectively;
  - both return to uaddr 0.
- jal (1101111): sequence 0,1,9,7,0; pc_write=1 at uaddr 9.
- Illegal opcode 1111111 at Decode:
  - without the macro -> uaddr returns to 0 with instr_done=1;
  - with the macro -> illegal=1, uaddr stays 1 with all enables 0, and reset clears it to uaddr 0;
  - additionally, reset asserted at uaddr 6 -> next uaddr is 0 and no enables are asserted.
